hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage pipelined RISC-V core; complements the EX-stage forwarding logic.
- Forwarding resolves every RAW hazard except load-use. This block detects load-use in ID and inserts bubbles.
- Squashes wrong-path instructions on an EX-resolved branch/jump mispredict.
- Drains the pipeline on a halt instruction (ecall with x17==10) before raising is_halted.
- Keeps saturating stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in HALT_DRAIN after the halt leaves ID; covers EX, MEM and WB retirement.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- IF_ID_rs1  in  5  rs1 field of the instruction in ID
- IF_ID_rs2  in  5  rs2 field of the instruction in ID
- IF_ID_use_rs1  in  1  ID instruction reads rs1
- IF_ID_use_rs2  in  1  ID instruction reads rs2
- IF_ID_is_halt  in  1  ID instruction is a halting ecall
- ID_EX_rd  in  5  destination register of the instruction in EX
- ID_EX_mem_read  in  1  instruction in EX is a load
- EX_mispredict  in  1  branch/jump resolved in EX disagrees with the fetched path
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  zero the IF/ID instruction (insert nop)
- ID_EX_flush  out  1  zero the ID/EX control bits (bubble)
- is_halted  out  1  pipeline fully drained after halt
- stall_count  out  CNT_WIDTH  number of load-use stall cycles
- flush_count  out  CNT_WIDTH  number of mispredict flush cycles

Behaviour:
- Definition: load_use = ID_EX_mem_read && ID_EX_rd!=0 && ((IF_ID_use_rs1 && IF_ID_rs1==ID_EX_rd) || (IF_ID_use_rs2 && IF_ID_rs2==ID_EX_rd)).
- FSM states: RUN, HALT_DRAIN, HALTED. Registered state, a drain counter, and the two counters.
- While reset is low (async): state=RUN, drain counter=0, both counters=0.
- While reset is low, outputs are: pc_write=0, IF_ID_write=0, both flushes=0, is_halted=0.
- RUN outputs are combinational (same cycle as inputs). Evaluate in this priority order:
  1. EX_mispredict: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_count+=1. A simultaneous load_use or IF_ID_is_halt is ignored, because the ID instruction is wrong-path.
  2. load_use: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=1; stall_count+=1. A halt in ID waits until the stall clears.
  3. IF_ID_is_halt: pc_write=0, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=0. The halt advances to EX and a nop enters ID. Next state is HALT_DRAIN with counter=DRAIN_CYCLES-1.
  4. Otherwise: pc_write=1, IF_ID_write=1, both flushes=0.
- HALT_DRAIN outputs: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, is_halted=0. All inputs are ignored.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is HALTED.
  - Exactly DRAIN_CYCLES cycles are spent in HALT_DRAIN.
- HALTED outputs: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, is_halted=1. HALTED is left only by reset.
- Counters are saturating: they hold at all-ones and do not wrap. They never increment outside RUN.
- is_halted is driven from the registered state; no glitches.
- Reset asserted mid-drain returns the FSM to RUN. The counters and is_halted clear immediately, without waiting for a clock edge.
- rd=x0 never causes a stall. A load into x0 followed by a use of x0 gives no stall.

Decomposition:
- Shared core package:
  - FSM state encodings (RUN, HALT_DRAIN, HALTED).
  - x0 constant.
  - Halt ecall constants: a7 register index 17, value 10.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, count), instantiated twice for stall_count and flush_count.
- Load-use compare and FSM stay inline.

Test Plan:
- Load-use: lw x5 in EX (ID_EX_mem_read=1, ID_EX_rd=5) with add in ID (rs1=5, use_rs1=1) -> in that cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1; stall_count 0->1; next cycle with mem_read=0, all enables return to 1.
- Load into x0: ID_EX_rd=0, mem_read=1, IF_ID_rs2=0, use_rs2=1 -> no stall (pc_write=1, ID_EX_flush=0); stall_count unchanged.
- Mispredict plus load_use in the same cycle: EX_mispredict=1 and a load_use match -> pc_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_count+=1; stall_count unchanged.
- Halt: IF_ID_is_halt=1 in RUN -> IF_ID_flush=1, pc_write=0; then 3 cycles of HALT_DRAIN with is_halted=0; is_halted=1 on the 4th cycle after the halt cycle and held indefinitely.
- Halt in ID behind a load-use stall -> 1 stall cycle first, then drain; is_halted rises one cycle later than in the previous scenario.
- Reset mid-drain and saturation:
  - Assert reset in the 2nd drain cycle -> is_halted=0 and counters=0 asynchronously; RUN behaviour after release.
  - With CNT_WIDTH=4, force 20 load-use stalls -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-index constants and the halting-ecall convention.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A halting ecall is recognised upstream as ecall with a7 (x17) == 10.
    localparam logic [4:0]  HALT_A7_REG   = 5'd17;
    localparam logic [31:0] HALT_A7_VALUE = 32'd10;

    localparam int DEFAULT_DRAIN_CYCLES = 3;
    localparam int DEFAULT_CNT_WIDTH    = 16;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubbles, mispredict squash, halt drain,
// plus saturating stall and flush performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IF_ID_rs1,
    input  logic [4:0]           IF_ID_rs2,
    input  logic                 IF_ID_use_rs1,
    input  logic                 IF_ID_use_rs2,
    input  logic                 IF_ID_is_halt,
    input  logic [4:0]           ID_EX_rd,
    input  logic                 ID_EX_mem_read,
    input  logic                 EX_mispredict,
    output logic                 pc_write,
    output logic                 IF_ID_write,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_flush,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output state_t               dbg_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   drain_nxt;

    logic            load_use;
    logic            pc_write_c;
    logic            if_id_write_c;
    logic            if_id_flush_c;
    logic            id_ex_flush_c;
    logic            stall_inc;
    logic            flush_inc;

    assign load_use = ID_EX_mem_read && (ID_EX_rd != REG_X0) &&
                      ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                       (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        case (state)
            ST_RUN: begin
                // A mispredict makes the ID instruction wrong-path, so it
                // overrides any stall or halt it might otherwise request.
                if (EX_mispredict) begin
                    pc_write_c    = 1'b1;
                    if_id_write_c = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    flush_inc     = 1'b1;
                end else if (load_use) begin
                    id_ex_flush_c = 1'b1;
                    stall_inc     = 1'b1;
                end else if (IF_ID_is_halt) begin
                    if_id_write_c = 1'b1;
                    if_id_flush_c = 1'b1;
                    state_nxt     = ST_HALT_DRAIN;
                    drain_nxt     = DW'(DRAIN_CYCLES - 1);
                end else begin
                    pc_write_c    = 1'b1;
                    if_id_write_c = 1'b1;
                end
            end

            ST_HALT_DRAIN: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (drain_cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_nxt = drain_cnt - DW'(1);
                end
            end

            ST_HALTED: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end

            default: begin
                state_nxt = ST_RUN;
                drain_nxt = '0;
            end
        endcase
    end

    // Enables and flushes are forced low while reset is held, independent of the clock.
    assign pc_write    = pc_write_c    & reset;
    assign IF_ID_write = if_id_write_c & reset;
    assign IF_ID_flush = if_id_flush_c & reset;
    assign ID_EX_flush = id_ex_flush_c & reset;

    assign is_halted = (state == ST_HALTED);
    assign dbg_state = state;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: driver pushes hand-computed responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int CW = 4;
    localparam int EW = 5 + 2 * CW;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]    IF_ID_rs1 = '0;
    logic [4:0]    IF_ID_rs2 = '0;
    logic          IF_ID_use_rs1 = 1'b0;
    logic          IF_ID_use_rs2 = 1'b0;
    logic          IF_ID_is_halt = 1'b0;
    logic [4:0]    ID_EX_rd = '0;
    logic          ID_EX_mem_read = 1'b0;
    logic          EX_mispredict = 1'b0;
    logic          pc_write;
    logic          IF_ID_write;
    logic          IF_ID_flush;
    logic          ID_EX_flush;
    logic          is_halted;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;
    state_t        dbg_state;

    hazard_control_unit #(.DRAIN_CYCLES(3), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .IF_ID_use_rs1  (IF_ID_use_rs1),
        .IF_ID_use_rs2  (IF_ID_use_rs2),
        .IF_ID_is_halt  (IF_ID_is_halt),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_mem_read (ID_EX_mem_read),
        .EX_mispredict  (EX_mispredict),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .is_halted      (is_halted),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .dbg_state      (dbg_state)
    );

    logic [EW-1:0] act;
    assign act = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, is_halted,
                  stall_count, flush_count};

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic logic [EW-1:0] pe(bit pc, bit w, bit ff, bit fx, bit h,
                                         int sc, int fc);
        return {pc, w, ff, fx, h, CW'(sc), CW'(fc)};
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // driver
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit halt,
                         input logic [4:0] rd, input bit mr, input bit mp,
                         input logic [EW-1:0] e, input string nm);
        @(posedge clk);
        #1;
        IF_ID_rs1      = rs1;
        IF_ID_rs2      = rs2;
        IF_ID_use_rs1  = u1;
        IF_ID_use_rs2  = u2;
        IF_ID_is_halt  = halt;
        ID_EX_rd       = rd;
        ID_EX_mem_read = mr;
        EX_mispredict  = mp;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_outputs"}, 32'(act), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_RUN));
        IF_ID_is_halt  = 1'b0;
        ID_EX_mem_read = 1'b0;
        EX_mispredict  = 1'b0;
        IF_ID_use_rs1  = 1'b0;
        IF_ID_use_rs2  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // monitor
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        string         nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, 32'(act), 32'(e));
        end
    end

    initial begin
        #2;
        check("init_rst_outputs", 32'(act), 32'd0);
        check("init_rst_state", 32'(dbg_state), 32'(ST_RUN));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(1,1,0,0,0,0,0), "idle");
        drive(5, 0, 1, 0, 0, 5, 1, 0, pe(0,0,0,1,0,0,0), "lu_rs1");
        drive(5, 0, 1, 0, 0, 5, 0, 0, pe(1,1,0,0,0,1,0), "lu_clear");
        drive(3, 7, 1, 1, 0, 7, 1, 0, pe(0,0,0,1,0,1,0), "lu_rs2");
        drive(9, 0, 0, 0, 0, 9, 1, 0, pe(1,1,0,0,0,2,0), "no_use_flag");
        drive(0, 0, 0, 1, 0, 0, 1, 0, pe(1,1,0,0,0,2,0), "load_x0");
        drive(5, 0, 1, 0, 0, 5, 0, 0, pe(1,1,0,0,0,2,0), "non_load");
        drive(6, 0, 1, 0, 1, 6, 1, 1, pe(1,1,1,1,0,2,0), "mp_over_lu");
        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(1,1,0,0,0,2,1), "idle_after_mp");
        drive(4, 0, 1, 0, 1, 4, 1, 0, pe(0,0,0,1,0,2,1), "halt_behind_lu");
        drive(4, 0, 1, 0, 1, 4, 0, 0, pe(0,1,1,0,0,3,1), "halt_issue");
        for (int i = 0; i < 3; i++)
            drive(4, 4, 1, 1, 1, 4, 1, 1, pe(0,0,1,1,0,3,1), "drain");
        for (int i = 0; i < 2; i++)
            drive(4, 4, 1, 1, 1, 4, 1, 1, pe(0,0,1,1,1,3,1), "halted");

        @(negedge clk);
        #1;
        reset_check("rst_halted");

        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(1,1,0,0,0,0,0), "post_rst_idle");
        drive(5, 0, 1, 0, 0, 5, 1, 0, pe(0,0,0,1,0,0,0), "lu_again");
        drive(0, 0, 0, 0, 0, 0, 0, 1, pe(1,1,1,1,0,1,0), "mispredict");
        drive(0, 0, 0, 0, 1, 0, 0, 0, pe(0,1,1,0,0,1,1), "halt_plain");
        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(0,0,1,1,0,1,1), "drain1");
        @(posedge clk);
        #1;
        reset_check("rst_mid_drain");

        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(1,1,0,0,0,0,0), "run_after_rst");
        drive(8, 0, 1, 0, 0, 8, 1, 0, pe(0,0,0,1,0,0,0), "lu_after_rst");
        for (int i = 0; i < 20; i++)
            drive(8, 0, 1, 0, 0, 8, 1, 0,
                  pe(0,0,0,1,0, (i + 1 > 15) ? 15 : i + 1, 0), "sat_stall");
        drive(0, 0, 0, 0, 0, 0, 0, 0, pe(1,1,0,0,0,15,0), "sat_hold");

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
